// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Definitions shared by the pipeline stages: opcode encodings,
//             the memory-stage FSM state type and an opcode normaliser.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_MUL  = 6'b100111;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_BLT  = 6'b010110;
    localparam logic [5:0] OP_BR   = 6'b000110;
    localparam logic [5:0] OP_BEQ  = 6'b100110;
    localparam logic [5:0] OP_NOPE = 6'b111111;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Any encoding outside the instruction set behaves as NOPE downstream.
    function automatic logic [5:0] norm_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_MUL, OP_ADDI, OP_LDW, OP_STW,
            OP_BLT, OP_BR, OP_BEQ, OP_NOPE: norm_op = op;
            default:                        norm_op = OP_NOPE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Purpose  : Word-addressed data memory, 2**ADDR_W x 32 bits.
//             Synchronous write, asynchronous (combinational) read.
//  Ports    : clk   - clock, rising edge
//             we    - write enable
//             addr  - word address
//             wdata - write data
//             rdata - read data (combinational from addr)
//  Revision : 1.0  initial release
// ============================================================================
module data_mem #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Memory-access pipeline stage. Executes LDW/STW against a local
//             data memory, registers write-back data/control, and stalls the
//             front of the pipeline while a load waits LOAD_WAIT cycles.
//  Config   : MEM_ERR_EN - adds mem_err_46, flags misaligned/out-of-range
//             LDW/STW and suppresses their memory/register effects.
//  Ports    : clk_46        in   clock, rising edge
//             rst_46        in   asynchronous active-low reset
//             opcode_46     in   opcode from execute
//             alu_out_46    in   ALU result / effective byte address
//             alu_src_46    in   store data
//             dest_reg_46   in   destination register field
//             targ_reg_46   in   target register field
//             stall_46      out  upstream must hold its inputs while high
//             opcode_out_46 out  registered opcode
//             wb_data_46    out  registered write-back value
//             wb_reg_46     out  registered write-back register index
//             reg_wr_46     out  registered register-write enable
//             mem_err_46    out  (MEM_ERR_EN only) registered access fault
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int LOAD_WAIT = 2
) (
    input  logic        clk_46,
    input  logic        rst_46,
    input  logic [5:0]  opcode_46,
    input  logic [31:0] alu_out_46,
    input  logic [31:0] alu_src_46,
    input  logic [5:0]  dest_reg_46,
    input  logic [5:0]  targ_reg_46,
    output logic        stall_46,
    output logic [5:0]  opcode_out_46,
    output logic [31:0] wb_data_46,
    output logic [5:0]  wb_reg_46,
    output logic        reg_wr_46
`ifdef MEM_ERR_EN
    ,
    output logic        mem_err_46
`endif
);

    localparam logic [3:0] WAIT_INIT = (LOAD_WAIT == 0) ? 4'd0 : 4'(LOAD_WAIT - 1);

    mem_state_t  state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [5:0]  op;
    logic [5:0]  opcode_nxt;
    logic [31:0] wb_data_nxt;
    logic [5:0]  wb_reg_nxt;
    logic        reg_wr_nxt;
    logic        mem_we;
    logic        stw_req;
    logic [31:0] rdata;
    logic        addr_err;
    logic        load_done;

    assign op = norm_op(opcode_46);

`ifdef MEM_ERR_EN
    localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);
    logic mem_err_nxt;
    assign addr_err    = (alu_out_46[1:0] != 2'b00) || ((alu_out_46 & HI_MASK) != 32'd0);
    assign mem_err_nxt = addr_err && ((state == RUN && op == OP_STW) || load_done);
`else
    assign addr_err = 1'b0;
`endif

    // The load completes either directly in RUN (no wait states) or on the
    // last WAIT cycle, using whatever inputs are held at that point.
    assign load_done = (state == RUN && op == OP_LDW && LOAD_WAIT == 0) ||
                       (state == WAIT && wait_cnt == 4'd0);

    // Gated by reset so that stall never shows while the stage is held in reset.
    assign stall_46 = rst_46 &&
                      ((state == RUN && op == OP_LDW && LOAD_WAIT != 0) ||
                       (state == WAIT && wait_cnt != 4'd0));

    // Writes are blocked during reset so random bus values cannot corrupt memory.
    assign mem_we = rst_46 && stw_req;

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk_46),
        .we    (mem_we),
        .addr  (alu_out_46[ADDR_W+1:2]),
        .wdata (alu_src_46),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        opcode_nxt   = op;
        wb_data_nxt  = 32'd0;
        wb_reg_nxt   = 6'd0;
        reg_wr_nxt   = 1'b0;
        stw_req      = 1'b0;

        if (state == WAIT) begin
            if (wait_cnt != 4'd0) begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                opcode_nxt   = OP_NOPE;
            end else begin
                state_nxt  = RUN;
                opcode_nxt = OP_LDW;
                if (!addr_err) begin
                    wb_data_nxt = rdata;
                    wb_reg_nxt  = targ_reg_46;
                    reg_wr_nxt  = 1'b1;
                end
            end
        end else begin
            case (op)
                OP_ADD, OP_MUL: begin
                    wb_data_nxt = alu_out_46;
                    wb_reg_nxt  = dest_reg_46;
                    reg_wr_nxt  = 1'b1;
                end
                OP_ADDI: begin
                    wb_data_nxt = alu_out_46;
                    wb_reg_nxt  = targ_reg_46;
                    reg_wr_nxt  = 1'b1;
                end
                OP_STW: begin
                    stw_req = !addr_err;
                end
                OP_LDW: begin
                    if (LOAD_WAIT == 0) begin
                        if (!addr_err) begin
                            wb_data_nxt = rdata;
                            wb_reg_nxt  = targ_reg_46;
                            reg_wr_nxt  = 1'b1;
                        end
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                        opcode_nxt   = OP_NOPE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            state         <= RUN;
            wait_cnt      <= 4'd0;
            opcode_out_46 <= 6'd0;
            wb_data_46    <= 32'd0;
            wb_reg_46     <= 6'd0;
            reg_wr_46     <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            opcode_out_46 <= opcode_nxt;
            wb_data_46    <= wb_data_nxt;
            wb_reg_46     <= wb_reg_nxt;
            reg_wr_46     <= reg_wr_nxt;
        end
    end

`ifdef MEM_ERR_EN
    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            mem_err_46 <= 1'b0;
        end else begin
            mem_err_46 <= mem_err_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
